bsg_wormhole_link_arbiter: RTL and testbench
============================================

# bsg_wormhole_link_arbiter

Shares one outbound wormhole link between `num_in_p` flit streams, each typically produced by a `bsg_wormhole_router_adapter_in`. Arbitration is round-robin at packet granularity: once a header flit wins, the winner holds the link until its last flit transfers, so packets are never interleaved. It sits between several adapters and a single router input port or flit FIFO.

## Interface
Parameters:
- `flit_width_p`, no default, width of one flit; must be ≥ `cord_width_p + len_width_p`.
- `num_in_p`, 2, number of requesting flit streams (≥ 1).
- `cord_width_p`, no default, destination coordinate field width in the header flit.
- `len_width_p`, no default, length field width; the field holds the count of flits *after* the header.

Ports:
- `clk_i` in 1: clock.
- `reset_i` in 1: synchronous, active-high reset.
- `link_v_i` in `num_in_p`: per-input flit valid.
- `link_data_i` in `num_in_p*flit_width_p`: per-input flit; input i occupies bits `[i*flit_width_p +: flit_width_p]`.
- `link_ready_and_o` out `num_in_p`: per-input ready; a flit transfers when `link_v_i[i] & link_ready_and_o[i]`.
- `link_v_o` out 1: output flit valid.
- `link_data_o` out `flit_width_p`: output flit.
- `link_ready_and_i` in 1: downstream ready; output transfer occurs on `link_v_o & link_ready_and_i`.
- `grant_id_o` out `max(1,clog2(num_in_p))`: index of the currently selected input; meaningful only when `link_v_o`.

## Operation
- Header layout: cord = `flit[cord_width_p-1:0]`, len = `flit[cord_width_p +: len_width_p]`. Remaining bits are payload and ignored.
- State machine with two states, IDLE and BUSY, plus a locked grant register, a flit counter (`len_width_p` bits), and a round-robin priority pointer.
- IDLE: among asserted `link_v_i`, the round-robin arbiter picks the first at or after the pointer. `link_v_o`=1 and `link_data_o`, `grant_id_o` come from the winner in the same cycle. On output transfer:
  - If len==0, the packet is complete: stay IDLE and advance the pointer to winner+1 (mod `num_in_p`).
  - If len>0, lock the grant, load counter=len, and go to BUSY.
- BUSY: only the locked input is connected. `link_v_o`=`link_v_i[grant]`. Each transfer decrements the counter. The transfer with counter==1 ends the packet: go to IDLE and advance the pointer to grant+1.
- `link_ready_and_o[i]` = `link_ready_and_i` when i is the selected/locked input, else 0.
- Gaps (`link_v_i[grant]`=0) inside a packet hold the lock. Other inputs are never granted mid-packet.
- Single input (`num_in_p`=1): the arbiter degenerates to a pass-through with the same lock and count behaviour.

## Timing
- Zero-latency datapath: input flit to output flit is combinational; all state updates on the clock edge of a transfer.
- `link_v_o` and `link_data_o` never depend combinationally on `link_ready_and_i`.
- `link_ready_and_o` may depend on `link_v_i` of other inputs (through arbitration) in IDLE only.
- Reset values: state=IDLE, pointer=0 (input 0 highest priority), counter=0, grant=0. During and right after reset, `link_v_o`=0 and `link_ready_and_o`=0 unless inputs are valid after reset deasserts.
- Reset mid-packet drops the lock. The next flit seen is treated as a header.
- Simultaneous requests in IDLE resolve by pointer. A new header on any input is grantable in the same cycle the previous packet's last flit transfers? No: the last flit's cycle belongs to the old grant, and the new header is granted at the earliest next cycle.

## Structure
- Header field extraction (`cord`, `len` offsets) and a `bsg_wormhole_header_s`-style typedef belong in the shared `bsg_wormhole_router_pkg`.
- One sub-module: `bsg_arb_round_robin` for the IDLE pick, with its yumi driven by header transfer with len==0 or by end-of-packet.
- The rest is the local FSM, counter, and output mux (`bsg_mux_one_hot`).

## Test plan
Settings: `flit_width_p`=8, `cord_width_p`=4, `len_width_p`=2, `num_in_p`=2.
- Single packet, input 0: header 8'h25 (len=2) followed by 2 body flits, `link_ready_and_i`=1. Expect 3 consecutive output flits on cycles 0–2 with `grant_id_o`=0, then IDLE.
- Contention: both inputs valid with len=1 packets from reset. Expect input 0's 2 flits, then input 1's 2 flits, then input 0 again (round-robin alternation). Input 1 sees `link_ready_and_o[1]`=0 throughout input 0's packet.
- No interleave under gaps: input 0 sends header len=2, drops valid for 3 cycles, then sends its body while input 1 is valid continuously. Expect zero input-1 flits until input 0's last flit transfers.
- Backpressure: `link_ready_and_i` toggles 1,0,1,0 during a len=3 packet. Expect exactly 4 transfers, stable `link_data_o` while stalled, and the counter decrementing only on transfers.
- Single-flit packets: header 8'h05 (len=0) on both inputs repeatedly. Expect grants 0,1,0,1 with no BUSY entry.
- Reset mid-packet: assert `reset_i` after a header (len=3) plus 1 body flit. Expect IDLE, pointer=0, and the next input-1 flit accepted as a header.

Source files
------------

// File: rtl/bsg_wormhole_router_pkg.sv
// Shared wormhole definitions: header field extraction and arbiter FSM encodings.
package bsg_wormhole_router_pkg;

    // Widest flit the header helpers accept.
    localparam int unsigned max_flit_width_lp = 512;

    // Link arbiter FSM states.
    localparam logic [0:0] state_idle_lp = 1'b0;
    localparam logic [0:0] state_busy_lp = 1'b1;

    // Decoded header fields, zero-extended to 32 bits.
    typedef struct packed {
        logic [31:0] len;
        logic [31:0] cord;
    } bsg_wormhole_header_s;

    // Extract a width-bit field starting at offset, zero-extended to 32 bits.
    function automatic logic [31:0] hdr_field(input logic [max_flit_width_lp-1:0] flit,
                                              input int unsigned offset,
                                              input int unsigned width);
        logic [31:0] mask;
        mask = (width >= 32) ? 32'hffff_ffff : ((32'd1 << width) - 32'd1);
        return 32'(flit >> offset) & mask;
    endfunction

    // Flit count following the header; len sits directly above cord.
    function automatic logic [31:0] hdr_len(input logic [max_flit_width_lp-1:0] flit,
                                            input int unsigned cord_width,
                                            input int unsigned len_width);
        return hdr_field(flit, cord_width, len_width);
    endfunction

    // Destination coordinate in the low bits of the header.
    function automatic logic [31:0] hdr_cord(input logic [max_flit_width_lp-1:0] flit,
                                             input int unsigned cord_width);
        return hdr_field(flit, 0, cord_width);
    endfunction

    // Full header decode.
    function automatic bsg_wormhole_header_s hdr_decode(input logic [max_flit_width_lp-1:0] flit,
                                                        input int unsigned cord_width,
                                                        input int unsigned len_width);
        bsg_wormhole_header_s h;
        h.cord = hdr_cord(flit, cord_width);
        h.len  = hdr_len(flit, cord_width, len_width);
        return h;
    endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin picker: first request at or after the priority pointer wins.
// The pointer moves to yumi_tag_i+1 when yumi_i reports a finished packet.
module bsg_arb_round_robin #(
    parameter  int unsigned width_p     = 2,
    localparam int unsigned id_width_lp = (width_p > 1) ? $clog2(width_p) : 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [width_p-1:0]     reqs_i,
    output logic [width_p-1:0]     grants_o,
    output logic [id_width_lp-1:0] tag_o,
    output logic                   v_o,
    input  logic                   yumi_i,
    input  logic [id_width_lp-1:0] yumi_tag_i
);

    logic [id_width_lp-1:0] ptr_q, ptr_d;

    // Scan from the pointer with wrap-around and keep the first requester.
    always_comb begin
        int unsigned idx;
        grants_o = '0;
        tag_o    = '0;
        v_o      = 1'b0;
        idx      = 0;
        for (int unsigned k = 0; k < width_p; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= width_p) idx = idx - width_p;
            for (int unsigned i = 0; i < width_p; i++) begin
                if (i == idx && reqs_i[i] && !v_o) begin
                    v_o         = 1'b1;
                    grants_o[i] = 1'b1;
                    tag_o       = id_width_lp'(i);
                end
            end
        end
    end

    // Next pointer: one past the input whose packet just completed.
    always_comb begin
        ptr_d = ptr_q;
        if (yumi_i) begin
            if (32'(yumi_tag_i) + 32'd1 >= width_p) ptr_d = '0;
            else                                    ptr_d = yumi_tag_i + id_width_lp'(1);
        end
    end

    // Pointer register; input 0 has highest priority out of reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

endmodule

// File: rtl/bsg_wormhole_link_arbiter.sv
// Packet-granular round-robin sharing of one wormhole link among num_in_p streams.
// Datapath is combinational; the header winner holds the link until its last flit.
module bsg_wormhole_link_arbiter
    import bsg_wormhole_router_pkg::*;
#(
    parameter  int unsigned flit_width_p = 8,
    parameter  int unsigned num_in_p     = 2,
    parameter  int unsigned cord_width_p = 4,
    parameter  int unsigned len_width_p  = 2,
    localparam int unsigned id_width_lp  = (num_in_p > 1) ? $clog2(num_in_p) : 1
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [num_in_p-1:0]              link_v_i,
    input  logic [num_in_p*flit_width_p-1:0] link_data_i,
    output logic [num_in_p-1:0]              link_ready_and_o,
    output logic                             link_v_o,
    output logic [flit_width_p-1:0]          link_data_o,
    input  logic                             link_ready_and_i,
    output logic [id_width_lp-1:0]           grant_id_o
);

    logic [0:0]             state_q, state_d;
    logic [id_width_lp-1:0] grant_q, grant_d;
    logic [len_width_p-1:0] cnt_q, cnt_d;

    logic [num_in_p-1:0]    arb_grants;
    logic [id_width_lp-1:0] arb_tag;
    logic                   arb_v;
    logic [num_in_p-1:0]    lock_onehot;
    logic [num_in_p-1:0]    sel_onehot;
    logic                   busy;
    logic                   xfer;
    logic                   yumi;
    logic [len_width_p-1:0] hdr_len_c;

    bsg_arb_round_robin #(
        .width_p (num_in_p)
    ) rr (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .reqs_i     (link_v_i),
        .grants_o   (arb_grants),
        .tag_o      (arb_tag),
        .v_o        (arb_v),
        .yumi_i     (yumi),
        .yumi_tag_i (grant_id_o)
    );

    assign busy = (state_q == state_busy_lp);

    // One-hot form of the locked grant.
    always_comb begin
        for (int unsigned i = 0; i < num_in_p; i++) begin
            lock_onehot[i] = (id_width_lp'(i) == grant_q);
        end
    end

    assign sel_onehot       = busy ? lock_onehot : arb_grants;
    assign grant_id_o       = busy ? grant_q : arb_tag;
    assign link_v_o         = busy ? |(lock_onehot & link_v_i) : arb_v;
    assign link_ready_and_o = sel_onehot & {num_in_p{link_ready_and_i}};
    assign xfer             = link_v_o & link_ready_and_i;

    // One-hot output mux over the input flits.
    always_comb begin
        link_data_o = '0;
        for (int unsigned i = 0; i < num_in_p; i++) begin
            link_data_o = link_data_o
                        | (link_data_i[i*flit_width_p +: flit_width_p] & {flit_width_p{sel_onehot[i]}});
        end
    end

    assign hdr_len_c = len_width_p'(hdr_len(max_flit_width_lp'(link_data_o), cord_width_p, len_width_p));

    // Next state: lock on multi-flit headers, count body flits, release on the last one.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        yumi    = 1'b0;
        case (state_q)
            state_idle_lp: begin
                if (xfer) begin
                    if (hdr_len_c == '0) begin
                        yumi = 1'b1;
                    end else begin
                        state_d = state_busy_lp;
                        grant_d = arb_tag;
                        cnt_d   = hdr_len_c;
                    end
                end
            end
            state_busy_lp: begin
                if (xfer) begin
                    cnt_d = cnt_q - len_width_p'(1);
                    if (cnt_q == len_width_p'(1)) begin
                        state_d = state_idle_lp;
                        yumi    = 1'b1;
                    end
                end
            end
            default: state_d = state_idle_lp;
        endcase
    end

    // State, lock and counter registers; reset drops any packet in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= state_idle_lp;
            grant_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_bsg_wormhole_link_arbiter.sv
// Randomized scoreboard bench for bsg_wormhole_link_arbiter (8-bit flits, 2 inputs).
module tb_bsg_wormhole_link_arbiter;

    localparam int FW = 8;
    localparam int CW = 4;
    localparam int LW = 2;
    localparam int NI = 2;

    logic                   clk;
    logic                   reset_i;
    logic [NI-1:0]          vin;
    logic [NI-1:0][FW-1:0]  din;
    logic [NI-1:0]          rdy_o;
    logic                   v_o;
    logic [FW-1:0]          d_o;
    logic                   rdy_i;
    logic [0:0]             gid;

    bsg_wormhole_link_arbiter #(
        .flit_width_p (FW),
        .num_in_p     (NI),
        .cord_width_p (CW),
        .len_width_p  (LW)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .link_v_i         (vin),
        .link_data_i      (din),
        .link_ready_and_o (rdy_o),
        .link_v_o         (v_o),
        .link_data_o      (d_o),
        .link_ready_and_i (rdy_i),
        .grant_id_o       (gid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Driver-side flit queues and scoreboard queues, one per input.
    logic [FW-1:0] src_q [NI][$];
    logic [FW-1:0] exp_q [NI][$];
    int            gid_log [$];

    logic [NI-1:0] acc_r;
    bit            rst_req;
    bit            gen_en;
    bit            rdy_rand;

    // Reference model state: packet ownership and priority.
    bit m_busy;
    int m_lock;
    int m_rem;
    int m_ptr;
    int n_xfer;
    int n_xfer_in [NI];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic inject(input int i, input logic [FW-1:0] hdr, input int nbody);
        logic [FW-1:0] f;
        src_q[i].push_back(hdr);
        exp_q[i].push_back(hdr);
        for (int b = 0; b < nbody; b++) begin
            f = FW'($urandom);
            src_q[i].push_back(f);
            exp_q[i].push_back(f);
        end
    endtask

    task automatic gen_packet(input int i);
        logic [1:0] len;
        logic [3:0] cord;
        logic [1:0] pl;
        len  = 2'($urandom);
        cord = 4'($urandom);
        pl   = 2'($urandom);
        inject(i, {pl, len, cord}, int'(len));
    endtask

    // One clock of stimulus, applied just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        reset_i = rst_req;
        if (reset_i) begin
            for (int i = 0; i < NI; i++) src_q[i].delete();
            vin   = '0;
            rdy_i = 1'b0;
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (acc_r[i]) begin
                    void'(src_q[i].pop_front());
                    vin[i] = 1'b0;
                end
                if (gen_en && src_q[i].size() == 0 && ($urandom % 4) == 0) gen_packet(i);
                if (!vin[i] && src_q[i].size() != 0) vin[i] = gen_en ? (($urandom % 3) != 0) : 1'b1;
                if (vin[i]) din[i] = src_q[i][0];
            end
            rdy_i = rdy_rand ? (($urandom % 4) != 0) : 1'b1;
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((src_q[0].size() != 0 || src_q[1].size() != 0 || vin != '0 || m_busy) && guard < 400) begin
            step();
            guard++;
        end
        chk("drain_bound", 32'(guard < 400), 32'd1);
    endtask

    // Monitor: derive the expected selection from the model and score every transfer.
    always @(negedge clk) begin
        bit            e_v;
        int            e_sel;
        int            idx;
        logic [NI-1:0] e_rdy;
        logic [FW-1:0] e_data;
        if (reset_i) begin
            chk("reset_v_o", 32'(v_o), 32'd0);
            chk("reset_ready_o", 32'(rdy_o), 32'd0);
            m_busy = 1'b0;
            m_ptr  = 0;
            m_rem  = 0;
            m_lock = 0;
            acc_r  = '0;
            for (int i = 0; i < NI; i++) exp_q[i].delete();
        end else begin
            e_v   = 1'b0;
            e_sel = 0;
            if (m_busy) begin
                e_sel = m_lock;
                e_v   = vin[m_lock];
            end else begin
                for (int k = 0; k < NI; k++) begin
                    idx = (m_ptr + k) % NI;
                    if (!e_v && vin[idx]) begin
                        e_v   = 1'b1;
                        e_sel = idx;
                    end
                end
            end
            chk("link_v_o", 32'(v_o), 32'(e_v));
            e_rdy = '0;
            if ((e_v || m_busy) && rdy_i) e_rdy[e_sel] = 1'b1;
            chk("link_ready_and_o", 32'(rdy_o), 32'(e_rdy));
            acc_r = vin & rdy_o;
            if (v_o && e_v) begin
                chk("grant_id_o", 32'(gid), 32'(e_sel));
                if (exp_q[e_sel].size() == 0) begin
                    chk("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    e_data = exp_q[e_sel][0];
                    chk("link_data_o", 32'(d_o), 32'(e_data));
                    if (rdy_i) begin
                        void'(exp_q[e_sel].pop_front());
                        n_xfer++;
                        n_xfer_in[e_sel]++;
                        gid_log.push_back(e_sel);
                        if (!m_busy) begin
                            if (e_data[CW +: LW] == 0) begin
                                m_ptr = (e_sel + 1) % NI;
                            end else begin
                                m_busy = 1'b1;
                                m_lock = e_sel;
                                m_rem  = int'(e_data[CW +: LW]);
                            end
                        end else begin
                            m_rem--;
                            if (m_rem == 0) begin
                                m_busy = 1'b0;
                                m_ptr  = (m_lock + 1) % NI;
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int base1;
        reset_i  = 1'b1;
        rst_req  = 1'b1;
        vin      = '0;
        din      = '0;
        rdy_i    = 1'b0;
        gen_en   = 1'b0;
        rdy_rand = 1'b0;
        acc_r    = '0;
        n_xfer   = 0;
        for (int i = 0; i < NI; i++) n_xfer_in[i] = 0;

        repeat (3) step();
        rst_req = 1'b0;
        step();
        @(negedge clk);
        #1;
        chk("idle_after_reset_v_o", 32'(v_o), 32'd0);

        // Single 3-flit packet on input 0 with no backpressure.
        base = n_xfer;
        inject(0, 8'h25, 2);
        repeat (3) step();
        @(negedge clk);
        #1;
        chk("single_pkt_xfers", 32'(n_xfer - base), 32'd3);
        chk("single_pkt_in0", 32'(n_xfer_in[0]), 32'd3);
        chk("single_pkt_idle", 32'(m_busy), 32'd0);

        // Random contention, gaps and backpressure.
        gen_en   = 1'b1;
        rdy_rand = 1'b1;
        repeat (4000) step();
        gen_en   = 1'b0;
        rdy_rand = 1'b0;
        drain();
        chk("random_exp0_empty", 32'(exp_q[0].size()), 32'd0);
        chk("random_exp1_empty", 32'(exp_q[1].size()), 32'd0);

        // Reset after header (len=3) plus one body flit; next input-1 flit is a header.
        inject(0, 8'h35, 3);
        step();
        step();
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        step();
        base1 = n_xfer_in[1];
        inject(1, 8'h05, 0);
        step();
        @(negedge clk);
        #1;
        chk("post_reset_hdr_in1", 32'(n_xfer_in[1] - base1), 32'd1);
        drain();

        // Repeated single-flit packets on both inputs alternate grants.
        gid_log.delete();
        for (int r = 0; r < 6; r++) begin
            inject(0, 8'h05, 0);
            inject(1, 8'h05, 0);
        end
        drain();
        chk("rr_log_len", 32'(gid_log.size()), 32'd12);
        for (int k = 1; k < gid_log.size(); k++) begin
            chk("rr_alternate", 32'(gid_log[k] ^ gid_log[k-1]), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
